// File: rtl/f8_mem_arbiter.sv
// Arbitrates one byte-wide sync RAM between cpu fetch/read/write ports and a DMA port; read done at N+2, write at N+1 cycles after grant.
// Backpressure: requesters hold req until their done pulse; cpu_stall holds the cpu while any cpu request is outstanding.
module f8_mem_arbiter #(
  parameter bit DMA_RR = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ireq,
  input  logic [15:0] iaddr,
  output logic [23:0] idata,
  output logic        idone,
  input  logic        dread_req,
  input  logic [15:0] dread_addr,
  output logic [15:0] dread_data,
  output logic        dread_done,
  input  logic [1:0]  dwrite_en,
  input  logic [15:0] dwrite_addr,
  input  logic [15:0] dwrite_data,
  output logic        dwrite_done,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic [15:0] dma_rdata,
  output logic        dma_done,
  output logic        cpu_stall,
  output logic [15:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;
  typedef enum logic [1:0] {OWN_IF, OWN_DR, OWN_DW, OWN_DMA} owner_t;

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d;
  logic [15:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic [1:0]  n_q, n_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  wen_q, wen_d;
  logic [15:0] wdata_q, wdata_d;
  logic        last_dma_q, last_dma_d;
  logic [23:0] rbuf_q, rbuf_d;
  logic [23:0] idata_q, idata_d;
  logic [15:0] dread_data_q, dread_data_d;
  logic [15:0] dma_rdata_q, dma_rdata_d;

  logic        cpu_any;
  logic        grant_dma;
  logic [1:0]  off;
  logic        mem_re_c, mem_we_c;
  logic [15:0] mem_addr_c;
  logic [7:0]  mem_wdata_c;

  assign cpu_any = ireq | dread_req | (|dwrite_en);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    wr_d         = wr_q;
    n_d          = n_q;
    cnt_d        = cnt_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    last_dma_d   = last_dma_q;
    rbuf_d       = rbuf_q;
    idata_d      = idata_q;
    dread_data_d = dread_data_q;
    dma_rdata_d  = dma_rdata_q;
    grant_dma    = 1'b0;
    mem_re_c     = 1'b0;
    mem_we_c     = 1'b0;
    mem_addr_c   = 16'h0000;
    mem_wdata_c  = 8'h00;
    // A lone upper-byte write starts at addr+1; otherwise bytes go out in cnt order.
    off = (wr_q && wen_q == 2'b10) ? 2'd1 : cnt_q;

    case (state_q)
      S_IDLE: begin
        if (cpu_any || dma_req) begin
          grant_dma  = dma_req && (!cpu_any || (DMA_RR && !last_dma_q));
          state_d    = S_XFER;
          cnt_d      = 2'd0;
          last_dma_d = grant_dma;
          if (grant_dma) begin
            owner_d = OWN_DMA;
            addr_d  = dma_addr;
            wr_d    = dma_we;
            n_d     = dma_we ? 2'd1 : 2'd2;
            wen_d   = 2'b01;
            wdata_d = {8'h00, dma_wdata};
          end else if (|dwrite_en) begin
            owner_d = OWN_DW;
            addr_d  = dwrite_addr;
            wr_d    = 1'b1;
            n_d     = {1'b0, dwrite_en[0]} + {1'b0, dwrite_en[1]};
            wen_d   = dwrite_en;
            wdata_d = dwrite_data;
          end else if (dread_req) begin
            owner_d = OWN_DR;
            addr_d  = dread_addr;
            wr_d    = 1'b0;
            n_d     = 2'd2;
          end else begin
            owner_d = OWN_IF;
            addr_d  = iaddr;
            wr_d    = 1'b0;
            n_d     = 2'd3;
          end
        end
      end
      S_XFER: begin
        if (wr_q) begin
          mem_we_c    = 1'b1;
          mem_addr_c  = addr_q + {14'b0, off};
          mem_wdata_c = off[0] ? wdata_q[15:8] : wdata_q[7:0];
          cnt_d       = cnt_q + 2'd1;
          if (cnt_q == n_q - 2'd1) state_d = S_DONE;
        end else begin
          if (cnt_q < n_q) begin
            mem_re_c   = 1'b1;
            mem_addr_c = addr_q + {14'b0, cnt_q};
          end
          case (cnt_q)
            2'd1:    rbuf_d[7:0]   = mem_rdata;
            2'd2:    rbuf_d[15:8]  = mem_rdata;
            2'd3:    rbuf_d[23:16] = mem_rdata;
            default: ;
          endcase
          cnt_d = cnt_q + 2'd1;
          // Results are published only on completion so outputs stay stable mid-transfer.
          if (cnt_q == n_q) begin
            state_d = S_DONE;
            case (owner_q)
              OWN_IF:  idata_d      = rbuf_d;
              OWN_DR:  dread_data_d = rbuf_d[15:0];
              OWN_DMA: dma_rdata_d  = rbuf_d[15:0];
              default: ;
            endcase
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_IF;
      addr_q       <= 16'h0000;
      wr_q         <= 1'b0;
      n_q          <= 2'd0;
      cnt_q        <= 2'd0;
      wen_q        <= 2'b00;
      wdata_q      <= 16'h0000;
      last_dma_q   <= 1'b0;
      rbuf_q       <= 24'h000000;
      idata_q      <= 24'h000000;
      dread_data_q <= 16'h0000;
      dma_rdata_q  <= 16'h0000;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      wr_q         <= wr_d;
      n_q          <= n_d;
      cnt_q        <= cnt_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      last_dma_q   <= last_dma_d;
      rbuf_q       <= rbuf_d;
      idata_q      <= idata_d;
      dread_data_q <= dread_data_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

  // Reset gates the RAM strobes combinationally so an aborted write never lands.
  assign mem_re    = mem_re_c & ~reset;
  assign mem_we    = mem_we_c & ~reset;
  assign mem_addr  = reset ? 16'h0000 : mem_addr_c;
  assign mem_wdata = reset ? 8'h00 : mem_wdata_c;

  assign idone       = !reset && state_q == S_DONE && owner_q == OWN_IF;
  assign dread_done  = !reset && state_q == S_DONE && owner_q == OWN_DR;
  assign dwrite_done = !reset && state_q == S_DONE && owner_q == OWN_DW;
  assign dma_done    = !reset && state_q == S_DONE && owner_q == OWN_DMA;

  assign idata      = idata_q;
  assign dread_data = dread_data_q;
  assign dma_rdata  = dma_rdata_q;

  assign cpu_stall = (ireq & ~idone) | (dread_req & ~dread_done) | ((|dwrite_en) & ~dwrite_done);

endmodule
